// File: rtl/axi4_ocram_pkg.sv
// rtl/axi4_ocram_pkg.sv - shared types, response codes and burst address step for the OCRAM controller
package axi4_ocram_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR,
        ST_BRESP,
        ST_RD
    } state_e;

    // Byte address of the following beat; burst code 2'b11 falls through to INCR.
    function automatic logic [63:0] next_addr(input logic [63:0] addr, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
        logic [63:0] incr;
        logic [63:0] mask;
        incr = 64'd1 << size;
        mask = (({56'd0, len} + 64'd1) << size) - 64'd1;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~mask) | ((addr + incr) & mask);
            default:     next_addr = addr + incr;
        endcase
    endfunction

endpackage

// File: rtl/axi4_ocram_rskid.sv
// rtl/axi4_ocram_rskid.sv - 2-entry flow-through read-return buffer with issue credit
module axi4_ocram_rskid #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [1:0]            in_resp,
    input  logic                  in_last,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            out_resp,
    output logic                  out_last,
    output logic                  credit
);

    logic [DATA_WIDTH-1:0] data_q [2];
    logic [1:0]            resp_q [2];
    logic                  last_q [2];
    logic [1:0]            cnt_q;
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic                  bypass;
    logic                  push;
    logic                  pop;
    logic [2:0]            cnt_nx;

    // An empty buffer passes the SRAM return straight through so rvalid follows the read by one cycle.
    always_comb begin
        bypass    = (cnt_q == 2'd0);
        out_valid = !bypass || in_valid;
        out_data  = '0;
        out_resp  = 2'b00;
        out_last  = 1'b0;
        if (out_valid) begin
            out_data = bypass ? in_data : data_q[rd_ptr_q];
            out_resp = bypass ? in_resp : resp_q[rd_ptr_q];
            out_last = bypass ? in_last : last_q[rd_ptr_q];
        end
        push   = in_valid && !(bypass && out_ready);
        pop    = out_valid && out_ready && !bypass;
        cnt_nx = {1'b0, cnt_q} + {2'b00, push} - {2'b00, pop};
        // A read issued now lands next cycle, so it needs a free slot after this cycle settles.
        credit = (cnt_nx < 3'd2);
    end

    // Occupancy and pointers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q    <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            cnt_q <= cnt_nx[1:0];
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
        end
    end

    // Entry storage; contents are only observed through valid entries.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr_q] <= in_data;
            resp_q[wr_ptr_q] <= in_resp;
            last_q[wr_ptr_q] <= in_last;
        end
    end

endmodule

// File: rtl/axi4_ocram_ctrl.sv
// rtl/axi4_ocram_ctrl.sv - AXI4 slave to single-port on-chip SRAM with burst support
module axi4_ocram_ctrl #(
    parameter int ID_WIDTH   = 8,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 4096,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [ID_WIDTH-1:0]          awid,
    input  logic [ADDR_WIDTH-1:0]        awaddr,
    input  logic [7:0]                   awlen,
    input  logic [2:0]                   awsize,
    input  logic [1:0]                   awburst,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [STRB_WIDTH-1:0]        wstrb,
    input  logic                         wlast,
    input  logic                         wvalid,
    output logic                         wready,
    output logic [ID_WIDTH-1:0]          bid,
    output logic [1:0]                   bresp,
    output logic                         bvalid,
    input  logic                         bready,
    input  logic [ID_WIDTH-1:0]          arid,
    input  logic [ADDR_WIDTH-1:0]        araddr,
    input  logic [7:0]                   arlen,
    input  logic [2:0]                   arsize,
    input  logic [1:0]                   arburst,
    input  logic                         arvalid,
    output logic                         arready,
    output logic [ID_WIDTH-1:0]          rid,
    output logic [DATA_WIDTH-1:0]        rdata,
    output logic [1:0]                   rresp,
    output logic                         rlast,
    output logic                         rvalid,
    input  logic                         rready,
    output logic                         sram_cs,
    output logic                         sram_we,
    output logic [STRB_WIDTH-1:0]        sram_be,
    output logic [$clog2(MEM_DEPTH)-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0]        sram_din,
    input  logic [DATA_WIDTH-1:0]        sram_dout
);
    import axi4_ocram_pkg::*;

    localparam int BW = $clog2(STRB_WIDTH);
    localparam int MW = $clog2(MEM_DEPTH);

    state_e                state_q, state_d;
    logic                  last_wr_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic [7:0]            cnt_q;
    logic                  err_q;
    logic                  iss_done_q;
    logic                  rd_pend_q, rd_pend_err_q, rd_pend_last_q;
    logic                  grant_w, grant_r, issue, credit, in_range;
    logic [63:0]           addr_wide;
    logic                  unused_ok;

    assign addr_wide = next_addr(64'(addr_q), len_q, size_q, burst_q);
    assign in_range  = (addr_q[ADDR_WIDTH-1:BW+MW] == '0);
    assign sram_addr = addr_q[BW +: MW];
    assign sram_be   = sram_we ? wstrb : '0;
    assign sram_din  = sram_we ? wdata : '0;
    assign bid       = id_q;
    assign rid       = id_q;
    assign bresp     = (bvalid && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign unused_ok = ^{wlast, addr_wide[63:ADDR_WIDTH]};

    // Next state, channel handshakes and SRAM strobes; AW/AR share one engine, so SRAM use is exclusive.
    always_comb begin
        state_d = state_q;
        awready = 1'b0;
        arready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        sram_cs = 1'b0;
        sram_we = 1'b0;
        issue   = 1'b0;
        grant_w = awvalid && (!arvalid || !last_wr_q);
        grant_r = arvalid && !grant_w;
        case (state_q)
            ST_IDLE: begin
                awready = grant_w;
                arready = grant_r;
                if (grant_w)      state_d = ST_WR;
                else if (grant_r) state_d = ST_RD;
            end
            ST_WR: begin
                wready = 1'b1;
                if (wvalid) begin
                    sram_cs = in_range;
                    sram_we = in_range;
                    if (cnt_q == len_q) state_d = ST_BRESP;
                end
            end
            ST_BRESP: begin
                bvalid = 1'b1;
                if (bready) state_d = ST_IDLE;
            end
            ST_RD: begin
                issue   = !iss_done_q && credit;
                sram_cs = issue && in_range;
                if (rvalid && rready && rlast) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Burst context, beat address/count and the one-cycle read-return tag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= ST_IDLE;
            last_wr_q      <= 1'b0;
            id_q           <= '0;
            addr_q         <= '0;
            len_q          <= '0;
            size_q         <= '0;
            burst_q        <= '0;
            cnt_q          <= '0;
            err_q          <= 1'b0;
            iss_done_q     <= 1'b0;
            rd_pend_q      <= 1'b0;
            rd_pend_err_q  <= 1'b0;
            rd_pend_last_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (awvalid && awready) begin
                id_q      <= awid;
                addr_q    <= awaddr;
                len_q     <= awlen;
                size_q    <= awsize;
                burst_q   <= awburst;
                cnt_q     <= '0;
                err_q     <= 1'b0;
                last_wr_q <= 1'b1;
            end else if (arvalid && arready) begin
                id_q       <= arid;
                addr_q     <= araddr;
                len_q      <= arlen;
                size_q     <= arsize;
                burst_q    <= arburst;
                cnt_q      <= '0;
                iss_done_q <= 1'b0;
                last_wr_q  <= 1'b0;
            end
            if (wvalid && wready) begin
                addr_q <= addr_wide[ADDR_WIDTH-1:0];
                cnt_q  <= cnt_q + 8'd1;
                if (!in_range) err_q <= 1'b1;
            end
            if (issue) begin
                addr_q <= addr_wide[ADDR_WIDTH-1:0];
                cnt_q  <= cnt_q + 8'd1;
                if (cnt_q == len_q) iss_done_q <= 1'b1;
            end
            rd_pend_q      <= issue;
            rd_pend_err_q  <= issue && !in_range;
            rd_pend_last_q <= issue && (cnt_q == len_q);
        end
    end

    axi4_ocram_rskid #(.DATA_WIDTH(DATA_WIDTH)) u_rskid (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (rd_pend_q),
        .in_data   (rd_pend_err_q ? '0 : sram_dout),
        .in_resp   (rd_pend_err_q ? RESP_SLVERR : RESP_OKAY),
        .in_last   (rd_pend_last_q),
        .out_ready (rready),
        .out_valid (rvalid),
        .out_data  (rdata),
        .out_resp  (rresp),
        .out_last  (rlast),
        .credit    (credit)
    );

endmodule

// File: tb/tb_axi4_ocram_ctrl.sv
// tb/tb_axi4_ocram_ctrl.sv - randomized self-checking bench for axi4_ocram_ctrl against a memory model
module tb_axi4_ocram_ctrl;

    localparam int IW = 8, DW = 64, AW = 32, DEPTH = 4096, SW = 8;

    logic clk = 1'b0;
    logic rstn;
    logic [IW-1:0] awid, arid, bid, rid;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0] awlen, arlen;
    logic [2:0] awsize, arsize;
    logic [1:0] awburst, arburst, bresp, rresp;
    logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rlast, rvalid, rready;
    logic [DW-1:0] wdata, rdata, sram_din, sram_dout;
    logic [SW-1:0] wstrb, sram_be;
    logic sram_cs, sram_we;
    logic [11:0] sram_addr;

    logic [63:0] sram    [0:DEPTH-1];
    logic [63:0] ref_mem [0:DEPTH-1];
    logic [63:0] wbuf [0:255];
    logic [7:0]  sbuf [0:255];
    logic [63:0] rd_q [$];
    logic [1:0]  rr_q [$];
    logic [11:0] rd_words [$];
    int          grants [$];
    int n_cmp = 0, n_bad = 0;
    int cyc = 0, cs_count = 0;
    int hs_cyc, first_cyc, last_cyc;

    axi4_ocram_ctrl dut (
        .clk(clk), .rstn(rstn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_be(sram_be), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (sram_cs && sram_we)
            for (int b = 0; b < SW; b++)
                if (sram_be[b]) sram[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
        if (sram_cs && !sram_we) sram_dout <= sram[sram_addr];
    end

    always @(negedge clk) begin
        if (sram_cs) cs_count++;
        if (sram_cs && !sram_we) rd_words.push_back(sram_addr);
        if (awvalid && awready) grants.push_back(1);
        if (arvalid && arready) grants.push_back(0);
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                              input int size, input int burst, input int i);
        longint unsigned incr, total, base;
        incr = 64'd1 << size;
        if (burst == 0) return start;
        if (burst == 2) begin
            total = (len + 1) * incr;
            base  = (start / total) * total;
            return 32'(base + ((start - base + i * incr) % total));
        end
        return 32'(start + i * incr);
    endfunction

    function automatic bit in_rng(input logic [31:0] a);
        return (a / SW) < DEPTH;
    endfunction

    task automatic axi_write(input logic [7:0] id, input logic [31:0] addr, input int len,
                             input int size, input int burst);
        int t;
        bit err = 0;
        logic [31:0] ba;
        awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst);
        awvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!awready && t < 200) begin @(negedge clk); t++; end
        chk("aw_handshake", awready, 1);
        @(posedge clk); #1 awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            wvalid = 1'b1; wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == len);
            t = 0;
            @(negedge clk);
            while (!wready && t < 200) begin @(negedge clk); t++; end
            chk("w_handshake", wready, 1);
            @(posedge clk); #1;
            ba = beat_addr(addr, len, size, burst, i);
            if (!in_rng(ba)) err = 1;
            else
                for (int b = 0; b < SW; b++)
                    if (sbuf[i][b]) ref_mem[ba / SW][8*b +: 8] = wbuf[i][8*b +: 8];
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        t = 0;
        @(negedge clk);
        while (!bvalid && t < 200) begin @(negedge clk); t++; end
        chk("b_handshake", bvalid, 1);
        chk("bresp", bresp, err ? 2'b10 : 2'b00);
        chk("bid", bid, id);
        @(posedge clk); #1 bready = 1'b0;
    endtask

    // mode 0: rready held high, 1: toggles 1010..., 2: random
    task automatic axi_read(input logic [7:0] id, input logic [31:0] addr, input int len,
                            input int size, input int burst, input int mode);
        int t, beat;
        logic [31:0] ba;
        logic [63:0] ed;
        rd_q.delete(); rr_q.delete();
        arid = id; araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst);
        arvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!arready && t < 200) begin @(negedge clk); t++; end
        chk("ar_handshake", arready, 1);
        hs_cyc = cyc;
        @(posedge clk); #1 arvalid = 1'b0;
        beat = 0; t = 0;
        while (beat <= len && t < 400) begin
            rready = (mode == 0) ? 1'b1 : (mode == 1) ? ((t % 2) == 0) : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (rvalid && rready) begin
                ba = beat_addr(addr, len, size, burst, beat);
                ed = in_rng(ba) ? ref_mem[ba / SW] : 64'd0;
                chk("rdata", rdata, ed);
                chk("rresp", rresp, in_rng(ba) ? 2'b00 : 2'b10);
                chk("rlast", rlast, beat == len);
                chk("rid", rid, id);
                rd_q.push_back(rdata); rr_q.push_back(rresp);
                if (beat == 0) first_cyc = cyc;
                last_cyc = cyc;
                beat++;
            end
            @(posedge clk); #1;
            t++;
        end
        rready = 1'b1;
        @(negedge clk);
        chk("r_no_extra_beat", rvalid, 0);
        chk("r_beat_count", beat, len + 1);
        @(posedge clk); #1 rready = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] v, init_word;
        int start_cs, burst, size, len;
        logic [31:0] addr;
        logic [11:0] exp3 [4];
        exp3 = '{12'd3, 12'd0, 12'd1, 12'd2};

        for (int i = 0; i < DEPTH; i++) begin
            v = {$urandom, $urandom};
            sram[i] = v; ref_mem[i] = v;
        end
        rstn = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {awready, arready, wready, bvalid, rvalid, sram_cs, sram_we, bresp, rresp}, 0);
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;

        // single narrow-strobe write then read back
        init_word = ref_mem['h200];
        wbuf[0] = 64'h1122334455667788; sbuf[0] = 8'h0F;
        axi_write(8'h11, 32'h1000, 0, 3, 1);
        axi_read(8'h12, 32'h1000, 0, 3, 1, 0);
        chk("t1_low_bytes", rd_q[0][31:0], 32'h55667788);
        chk("t1_high_bytes", rd_q[0][63:32], init_word[63:32]);
        chk("t1_resp", rr_q[0], 2'b00);

        // INCR len 7, full-rate read
        for (int i = 0; i < 8; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
        axi_write(8'h21, 32'h200, 7, 3, 1);
        axi_read(8'h22, 32'h200, 7, 3, 1, 0);
        chk("t2_first_latency", first_cyc - hs_cyc, 2);
        chk("t2_consecutive", last_cyc - first_cyc, 7);

        // WRAP word order
        rd_words.delete();
        axi_read(8'h31, 32'h18, 3, 3, 2, 0);
        chk("t3_word_count", rd_words.size(), 4);
        for (int i = 0; i < 4 && i < rd_words.size(); i++) chk("t3_wrap_word", rd_words[i], exp3[i]);

        // INCR len 15 with toggling rready
        for (int i = 0; i < 16; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
        axi_write(8'h41, 32'h400, 15, 3, 1);
        axi_read(8'h42, 32'h400, 15, 3, 1, 1);

        // out of range
        start_cs = cs_count;
        axi_read(8'h61, 32'h8000, 0, 3, 1, 0);
        chk("t6_rdata_zero", rd_q[0], 0);
        chk("t6_rresp_slverr", rr_q[0], 2'b10);
        wbuf[0] = {$urandom, $urandom}; sbuf[0] = 8'hFF;
        axi_write(8'h62, 32'h8000, 0, 3, 1);
        chk("t6_no_sram_cs", cs_count - start_cs, 0);

        // reset in the middle of a stalled read burst
        arid = 8'h71; araddr = 32'h800; arlen = 8'd15; arsize = 3'd3; arburst = 2'd1; arvalid = 1'b1;
        @(negedge clk);
        chk("rst_ar_ready", arready, 1);
        @(posedge clk); #1 arvalid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_rvalid", rvalid, 1);
        @(posedge clk); #1 rstn = 1'b0;
        @(negedge clk);
        chk("mid_burst_reset", {awready, arready, wready, bvalid, rvalid, rlast, sram_cs, sram_we, bresp, rresp}, 0);
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;

        // simultaneous AW/AR: write wins first after reset, then alternation
        grants.delete();
        for (int r = 0; r < 4; r++) begin
            wbuf[0] = {$urandom, $urandom}; wbuf[1] = {$urandom, $urandom}; sbuf[0] = 8'hFF; sbuf[1] = 8'hFF;
            fork
                axi_write(8'(8'h80 + r), 32'h3000 + 32'(r * 'h40), 1, 3, 1);
                axi_read(8'(8'h90 + r), 32'h100 + 32'(r * 'h40), 1, 3, 1, 0);
            join
        end
        chk("t5_grant_count", grants.size(), 8);
        for (int i = 0; i < 8 && i < grants.size(); i++) chk("t5_grant_order", grants[i], (i % 2 == 0) ? 1 : 0);
        wbuf[0] = {$urandom, $urandom}; sbuf[0] = 8'hFF;
        axi_write(8'hA0, 32'h3400, 0, 3, 1);
        grants.delete();
        fork
            axi_write(8'hA1, 32'h3440, 0, 3, 1);
            axi_read(8'hA2, 32'h3480, 0, 3, 1, 0);
        join
        chk("t5_read_after_write_wins", grants.size() > 0 ? grants[0] : -1, 0);

        // randomized mix
        for (int n = 0; n < 30; n++) begin
            burst = $urandom_range(0, 3);
            size  = $urandom_range(0, 3);
            len   = (burst == 2) ? ((2 << $urandom_range(0, 3)) - 1) : $urandom_range(0, 15);
            addr  = $urandom_range(0, 'h8080) & ~((32'd1 << size) - 1);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i <= len; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'($urandom_range(0, 255)); end
                axi_write(8'($urandom_range(0, 255)), addr, len, size, burst);
            end else begin
                axi_read(8'($urandom_range(0, 255)), addr, len, size, burst, 2);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
